dmi_responder: RTL and testbench
================================

DMI_RESPONDER -- requirements
Module: dmi_responder

Interface
REQ-001 SHALL have parameter DmVersion, default 4'd2, value reported in dmstatus.version.
REQ-002 SHALL have parameter DataCount, default 2, number of data registers (1 or 2), reported in abstractcs.datacount.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-005 SHALL have port dmi_clear_i  input  1  synchronous clear from DTM (dmireset/hard reset).
REQ-006 SHALL have port dmi_req_i  input  dm::dmi_req_t (41: addr[6:0], op[1:0], data[31:0])  request; op 0=nop, 1=read, 2=write.
REQ-007 SHALL have port dmi_req_valid_i  input  1, and port dmi_req_ready_o  output  1.
REQ-008 SHALL have port dmi_resp_o  output  dm::dmi_resp_t (34: data[31:0], resp[1:0])  response; resp 0=success, 2=failed.
REQ-009 SHALL have port dmi_resp_valid_o  output  1, and port dmi_resp_ready_i  input  1.
REQ-010 SHALL have ports haltreq_o, ndmreset_o, dmactive_o  output  1 each, level from dmcontrol; resumereq_o  output  1  one-cycle pulse.
REQ-011 SHALL have ports hart_halted_i, hart_resumeack_i  input  1 each  hart status.

Function
REQ-012 FSM states IDLE, RESP; dmi_req_ready_o = (state==IDLE); dmi_resp_valid_o = (state==RESP).
REQ-013 IDLE->RESP on dmi_req_valid_i & dmi_req_ready_o; response registered, valid on next cycle (latency 1); RESP->IDLE on dmi_resp_ready_i.
REQ-014 In RESP, dmi_resp_o SHALL hold stable until accepted; no new request accepted (back-to-back throughput one per 2 cycles).
REQ-015 Register map: 0x04 data0 RW, 0x05 data1 RW (only if DataCount==2), 0x10 dmcontrol RW, 0x11 dmstatus RO, 0x16 abstractcs RO.
REQ-016 dmcontrol bits: [0] dmactive, [1] ndmreset, [31] haltreq stored; [30] resumereq write-only, reads 0; other bits read 0.
REQ-017 Write to dmcontrol with data[30]=1 SHALL pulse resumereq_o for exactly one cycle after acceptance and clear the resumeack flag.
REQ-018 Resumeack flag SHALL set on hart_resumeack_i and hold until next resumereq write or reset.
REQ-019 dmstatus: [3:0] DmVersion, [7] authenticated=1, [8]/[9] anyhalted/allhalted=hart_halted_i, [10]/[11] anyrunning/allrunning=!hart_halted_i, [16]/[17] anyresumeack/allresumeack=flag; others 0.
REQ-020 abstractcs reads {28'b0, DataCount[3:0]}.
REQ-021 While dmactive==0: data0/data1 held at 0, writes to them ignored; dmcontrol writes always honoured.
REQ-022 Read response data = register value sampled at acceptance; write/nop response data = 0, resp = 0.
REQ-023 Writes to RO registers SHALL be ignored with resp=0.
REQ-024 dmi_clear_i SHALL force state IDLE, drop any pending response, next cycle; registers unaffected; a request valid in the same cycle SHALL NOT be accepted.
REQ-025 op==3 SHALL be treated as nop unless REQ-030 applies.

Reset
REQ-026 On rst_i: state IDLE, dmi_resp_valid_o=0, dmi_resp_o=0, dmi_req_ready_o=1 from the following cycle.
REQ-027 On rst_i: data0=data1=0, dmcontrol=0 (haltreq_o=ndmreset_o=dmactive_o=0), resumereq_o=0, resumeack flag=0.
REQ-028 rst_i mid-transaction SHALL abort the pending response; rst_i has priority over dmi_clear_i and requests.

Configuration
REQ-029 Macro DMI_ERR_RESP_EN selects error reporting.
REQ-030 Defined: access to unmapped address or op==3 SHALL return resp=2 (failed), data=0, no state change.
REQ-031 Undefined: unmapped reads return data=0 resp=0, unmapped writes ignored resp=0, op==3 as nop.

Verification
REQ-032 Reset, write dmcontrol 0x00000001 -> dmactive_o=1; read 0x10 -> data 0x00000001 resp 0, valid exactly 1 cycle after acceptance.
REQ-033 dmactive=1, write 0x04 0xDEADBEEF, read 0x04 -> 0xDEADBEEF; write dmcontrol 0 then read 0x04 -> 0x00000000.
REQ-034 hart_halted_i=1, read 0x11 -> 0x00000382; write dmcontrol 0x40000001 -> resumereq_o high 1 cycle; pulse hart_resumeack_i, read 0x11 with halted=0 -> 0x00030C82.
REQ-035 Hold dmi_resp_ready_i=0 5 cycles -> dmi_resp_o stable, dmi_req_ready_o=0; assert dmi_clear_i -> valid drops next cycle, ready=1.
REQ-036 Read 0x7F: with DMI_ERR_RESP_EN -> resp 2 data 0; without -> resp 0 data 0.
REQ-037 Assert rst_i while in RESP -> dmi_resp_valid_o=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/dmi_responder.sv
// dmi_responder: single-hart RISC-V DMI register responder (data0/1, dmcontrol, dmstatus, abstractcs).
// Define DMI_ERR_RESP_EN to answer unmapped addresses and op==3 with resp=2 (failed).
package dm;
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_responder #(
  parameter logic [3:0]  DmVersion = 4'd2,
  parameter int unsigned DataCount = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          dmi_clear_i,
  input  dm::dmi_req_t  dmi_req_i,
  input  logic          dmi_req_valid_i,
  output logic          dmi_req_ready_o,
  output dm::dmi_resp_t dmi_resp_o,
  output logic          dmi_resp_valid_o,
  input  logic          dmi_resp_ready_i,
  output logic          haltreq_o,
  output logic          resumereq_o,
  output logic          ndmreset_o,
  output logic          dmactive_o,
  input  logic          hart_halted_i,
  input  logic          hart_resumeack_i
);
  typedef enum logic {IDLE, RESP} state_e;
  localparam logic [3:0] DcBits = 4'(DataCount);
  localparam logic HasData1 = DataCount == 2;
  state_e state_q, state_d;
  dm::dmi_resp_t resp_q, resp_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d, rdata;
  logic dmactive_q, dmactive_d, ndmreset_q, ndmreset_d, haltreq_q, haltreq_d;
  logic resumereq_q, resumereq_d, resumeack_q, resumeack_d;
  logic accept, mapped, err, rd, wr, wr_ctl;
  always_comb begin
    accept = state_q == IDLE && dmi_req_valid_i && !dmi_clear_i;
    mapped = 1'b1;
    rdata = '0;
    case (dmi_req_i.addr)
      7'h04: rdata = data0_q;
      7'h05: begin rdata = HasData1 ? data1_q : '0; mapped = HasData1; end
      7'h10: rdata = {haltreq_q, 29'b0, ndmreset_q, dmactive_q};
      7'h11: rdata = {14'b0, {2{resumeack_q}}, 4'b0, {2{!hart_halted_i}}, {2{hart_halted_i}}, 1'b1, 3'b0, DmVersion};
      7'h16: rdata = {28'b0, DcBits};
      default: mapped = 1'b0;
    endcase
`ifdef DMI_ERR_RESP_EN
    err = !mapped || dmi_req_i.op == 2'd3;
`else
    err = 1'b0;
`endif
    rd = accept && !err && dmi_req_i.op == 2'd1;
    wr = accept && !err && dmi_req_i.op == 2'd2 && mapped;
    wr_ctl = wr && dmi_req_i.addr == 7'h10;
    state_d = dmi_clear_i ? IDLE : accept ? RESP : (state_q == RESP && dmi_resp_ready_i) ? IDLE : state_q;
    resp_d = dmi_clear_i ? '0 : accept ? {rd ? rdata : 32'h0, err ? 2'd2 : 2'd0} : resp_q;
    dmactive_d = wr_ctl ? dmi_req_i.data[0] : dmactive_q;
    ndmreset_d = wr_ctl ? dmi_req_i.data[1] : ndmreset_q;
    haltreq_d = wr_ctl ? dmi_req_i.data[31] : haltreq_q;
    resumereq_d = wr_ctl && dmi_req_i.data[30];
    resumeack_d = resumereq_d ? 1'b0 : resumeack_q || hart_resumeack_i;
    // data registers are forced to zero whenever the DM is inactive
    data0_d = !dmactive_q ? '0 : (wr && dmi_req_i.addr == 7'h04) ? dmi_req_i.data : data0_q;
    data1_d = (!dmactive_q || !HasData1) ? '0 : (wr && dmi_req_i.addr == 7'h05) ? dmi_req_i.data : data1_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      resp_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
      dmactive_q <= 1'b0;
      ndmreset_q <= 1'b0;
      haltreq_q <= 1'b0;
      resumereq_q <= 1'b0;
      resumeack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q <= resp_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      dmactive_q <= dmactive_d;
      ndmreset_q <= ndmreset_d;
      haltreq_q <= haltreq_d;
      resumereq_q <= resumereq_d;
      resumeack_q <= resumeack_d;
    end
  end
  assign dmi_req_ready_o = state_q == IDLE;
  assign dmi_resp_valid_o = state_q == RESP;
  assign dmi_resp_o = resp_q;
  assign haltreq_o = haltreq_q;
  assign ndmreset_o = ndmreset_q;
  assign dmactive_o = dmactive_q;
  assign resumereq_o = resumereq_q;
endmodule

// File: tb/tb_dmi_responder.sv
// tb_dmi_responder: directed and randomized checks of dmi_responder against a register-level model.
module tb_dmi_responder;
  logic clk_i = 0, rst_i = 1, dmi_clear_i = 0, dmi_req_valid_i = 0, dmi_resp_ready_i = 0;
  logic hart_halted_i = 0, hart_resumeack_i = 0;
  dm::dmi_req_t dmi_req_i = '0;
  dm::dmi_resp_t dmi_resp_o;
  logic dmi_req_ready_o, dmi_resp_valid_o, haltreq_o, resumereq_o, ndmreset_o, dmactive_o;
  int checks = 0, passed = 0;
  logic [31:0] m_d0, m_d1;
  logic m_act, m_ndm, m_halt, m_ack;
  logic [31:0] rdat, held;
  logic [1:0] rcode;
  logic pulse;

  dmi_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .dmi_clear_i(dmi_clear_i),
    .dmi_req_i(dmi_req_i), .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_resp_o(dmi_resp_o), .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
    .haltreq_o(haltreq_o), .resumereq_o(resumereq_o), .ndmreset_o(ndmreset_o), .dmactive_o(dmactive_o),
    .hart_halted_i(hart_halted_i), .hart_resumeack_i(hart_resumeack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic is_err(input logic [6:0] a, input logic [1:0] op);
`ifdef DMI_ERR_RESP_EN
    return !(a inside {7'h04, 7'h05, 7'h10, 7'h11, 7'h16}) || op == 2'd3;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [33:0] exp_resp(input logic [6:0] a, input logic [1:0] op);
    logic [31:0] v;
    if (is_err(a, op)) return {32'h0, 2'd2};
    if (op != 2'd1) return '0;
    v = 0;
    if (a == 7'h04) v = m_d0;
    if (a == 7'h05) v = m_d1;
    if (a == 7'h10) v = (m_halt ? 32'h8000_0000 : 0) + (m_ndm ? 2 : 0) + (m_act ? 1 : 0);
    if (a == 7'h11) v = 2 + 'h80 + (hart_halted_i ? 'h300 : 'hC00) + (m_ack ? 'h30000 : 0);
    if (a == 7'h16) v = 2;
    return {v, 2'd0};
  endfunction

  task automatic m_apply(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
    if (is_err(a, op) || op != 2'd2) return;
    if (a == 7'h10) begin
      m_act = d[0]; m_ndm = d[1]; m_halt = d[31];
      if (d[30]) m_ack = 0;
    end
    if (a == 7'h04 && m_act) m_d0 = d;
    if (a == 7'h05 && m_act) m_d1 = d;
    if (!m_act) begin m_d0 = 0; m_d1 = 0; end
  endtask

  task automatic m_reset;
    m_d0 = 0; m_d1 = 0; m_act = 0; m_ndm = 0; m_halt = 0; m_ack = 0;
  endtask

  // one full handshake; returns the response and whether resumereq_o pulsed after acceptance
  task automatic xfer(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d, input int stall,
                      output logic [31:0] rd, output logic [1:0] rc, output logic pr);
    dmi_req_i = '{addr: a, op: op, data: d};
    dmi_req_valid_i = 1;
    check("req_ready_idle", dmi_req_ready_o, 1);
    check("resp_valid_pre", dmi_resp_valid_o, 0);
    tick;
    dmi_req_valid_i = 0;
    dmi_req_i = '{addr: 7'($urandom), op: 2'($urandom), data: $urandom};
    check("resp_valid_lat1", dmi_resp_valid_o, 1);
    rd = dmi_resp_o.data;
    rc = dmi_resp_o.resp;
    pr = resumereq_o;
    for (int i = 0; i < stall; i++) begin
      tick;
      check("resp_hold", {dmi_resp_o.data, dmi_resp_o.resp}, {rd, rc});
      check("req_ready_busy", dmi_req_ready_o, 0);
    end
    dmi_resp_ready_i = 1;
    tick;
    dmi_resp_ready_i = 0;
    check("resp_valid_drop", dmi_resp_valid_o, 0);
    check("resumereq_1cyc", resumereq_o, 0);
  endtask

  task automatic txn(input string tag, input logic [6:0] a, input logic [1:0] op, input logic [31:0] d, input int stall);
    logic [33:0] e;
    logic ep;
    e = exp_resp(a, op);
    ep = !is_err(a, op) && op == 2'd2 && a == 7'h10 && d[30];
    xfer(a, op, d, stall, rdat, rcode, pulse);
    m_apply(a, op, d);
    check(tag, {rdat, rcode}, e);
    check("resumereq_pulse", pulse, ep);
    check("ctl_outputs", {haltreq_o, ndmreset_o, dmactive_o}, {m_halt, m_ndm, m_act});
  endtask

  initial begin
    logic [6:0] addrs [8];
    addrs = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h16, 7'h00, 7'h7F, 7'h12};
    m_reset();
    repeat (2) tick;
    rst_i = 0;
    check("rst_ready", dmi_req_ready_o, 1);
    check("rst_valid", dmi_resp_valid_o, 0);
    check("rst_resp", dmi_resp_o, 0);
    check("rst_ctl", {haltreq_o, ndmreset_o, dmactive_o, resumereq_o}, 0);
    txn("wr_dmcontrol", 7'h10, 2, 32'h0000_0001, 0);
    check("dmactive_set", dmactive_o, 1);
    txn("rd_dmcontrol", 7'h10, 1, 0, 0);
    check("rd_dmcontrol_val", rdat, 32'h0000_0001);
    txn("wr_data0", 7'h04, 2, 32'hDEAD_BEEF, 0);
    txn("rd_data0", 7'h04, 1, 0, 0);
    check("rd_data0_val", rdat, 32'hDEAD_BEEF);
    txn("wr_dmcontrol0", 7'h10, 2, 0, 0);
    txn("rd_data0_inact", 7'h04, 1, 0, 0);
    check("rd_data0_zero", rdat, 0);
    txn("wr_data0_inact", 7'h04, 2, 32'h1234_5678, 0);
    txn("rd_data0_ign", 7'h04, 1, 0, 0);
    hart_halted_i = 1;
    txn("rd_dmstatus_h", 7'h11, 1, 0, 0);
    check("dmstatus_halted", rdat, 32'h0000_0382);
    txn("wr_resumereq", 7'h10, 2, 32'h4000_0001, 0);
    check("resumereq_seen", pulse, 1);
    hart_resumeack_i = 1; tick; hart_resumeack_i = 0; m_ack = 1;
    hart_halted_i = 0;
    txn("rd_dmstatus_r", 7'h11, 1, 0, 0);
    check("dmstatus_ack", rdat, 32'h0003_0C82);
    txn("rd_abstractcs", 7'h16, 1, 0, 0);
    txn("wr_ro_ignored", 7'h11, 2, 32'hFFFF_FFFF, 0);
    txn("wr_data1", 7'h05, 2, 32'hCAFE_F00D, 0);
    txn("rd_data1", 7'h05, 1, 0, 2);
    // stalled response, then dmi_clear drops it and blocks a same-cycle request
    dmi_req_i = '{addr: 7'h05, op: 2'd1, data: 0};
    dmi_req_valid_i = 1;
    tick;
    dmi_req_valid_i = 0;
    held = dmi_resp_o.data;
    check("stall_first", held, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("stall_hold", dmi_resp_o.data, held);
      check("stall_valid", dmi_resp_valid_o, 1);
      check("stall_ready", dmi_req_ready_o, 0);
    end
    dmi_clear_i = 1;
    dmi_req_valid_i = 1;
    tick;
    check("clear_valid", dmi_resp_valid_o, 0);
    check("clear_ready", dmi_req_ready_o, 1);
    tick;
    check("clear_noaccept", dmi_resp_valid_o, 0);
    dmi_clear_i = 0;
    dmi_req_valid_i = 0;
    txn("rd_after_clear", 7'h05, 1, 0, 0);
    txn("rd_unmapped", 7'h7F, 1, 0, 0);
    txn("op3", 7'h04, 3, 32'hFFFF_FFFF, 0);
    txn("wr_unmapped", 7'h7F, 2, 32'hFFFF_FFFF, 0);
    for (int n = 0; n < 80; n++) begin
      logic [6:0] a;
      logic [31:0] d;
      a = addrs[$urandom_range(0, 7)];
      d = $urandom;
      if (a == 7'h10 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      hart_halted_i = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        hart_resumeack_i = 1; tick; hart_resumeack_i = 0; m_ack = 1;
      end
      txn("rand", a, 2'($urandom), d, $urandom_range(0, 2));
    end
    txn("wr_ctl_all", 7'h10, 2, 32'h8000_0003, 0);
    dmi_req_i = '{addr: 7'h04, op: 2'd1, data: 0};
    dmi_req_valid_i = 1;
    tick;
    dmi_req_valid_i = 0;
    check("pre_rst_valid", dmi_resp_valid_o, 1);
    rst_i = 1;
    dmi_clear_i = 1;
    tick;
    rst_i = 0;
    dmi_clear_i = 0;
    m_reset();
    check("rst_mid_valid", dmi_resp_valid_o, 0);
    check("rst_mid_resp", dmi_resp_o, 0);
    check("rst_mid_ready", dmi_req_ready_o, 1);
    check("rst_mid_ctl", {haltreq_o, ndmreset_o, dmactive_o, resumereq_o}, 0);
    txn("rd_ctl_after_rst", 7'h10, 1, 0, 0);
    txn("rd_data0_after_rst", 7'h04, 1, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
